// File: rtl/conv_sequencer.sv
// conv_sequencer: sequences one full-image convolution pass over the
// conv_memory window buffer and the pixel_pos scan counter.
// Starts a transaction, waits for each window to fill, hands it downstream
// over valid/ready and advances the scan until every pixel is visited.
// Optional fill watchdog: define CONV_SEQ_TIMEOUT_EN to enable it.
// All outputs are registered or decoded from the state register only.

module conv_sequencer #(
   parameter int X_MAX          = 16,
   parameter int Y_MAX          = 16,
   parameter int MAX_KERNAL     = 9,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                               clk,
   input  logic                               n_rst,
   input  logic                               start,
   input  logic                               abort,
   input  logic [$clog2(X_MAX):0]             cfg_max_x,
   input  logic [$clog2(Y_MAX):0]             cfg_max_y,
   input  logic [7:0]                         cfg_kernel,
   output logic                               new_trans,
   output logic                               new_sample_req,
   input  logic                               new_sample_ready,
   output logic                               win_valid,
   input  logic                               win_ready,
   output logic                               busy,
   output logic                               done,
   output logic                               cfg_err,
   output logic                               timeout_err,
   output logic [$clog2(X_MAX*Y_MAX):0]       pix_count
);

   localparam int XW = $clog2(X_MAX) + 1;
   localparam int YW = $clog2(Y_MAX) + 1;
   localparam int PW = $clog2(X_MAX * Y_MAX) + 1;

   localparam logic [XW-1:0] LP_X_MAX = XW'(X_MAX);
   localparam logic [YW-1:0] LP_Y_MAX = YW'(Y_MAX);
   localparam logic [7:0]    LP_K_MAX = 8'(MAX_KERNAL);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_DRAIN,
      ST_FILL,
      ST_PRESENT,
      ST_ADVANCE,
      ST_FINISH
   } state_t;

   state_t          r_state;
   state_t          w_state_next;

   logic [XW-1:0]   r_max_x;
   logic [YW-1:0]   r_max_y;
   logic [7:0]      r_kernel;
   logic [PW-1:0]   r_pix_count;
   logic            r_cfg_err;

   logic            w_cfg_illegal;
   logic            w_start_ok;
   logic            w_handshake;
   logic [PW-1:0]   w_pix_inc;
   logic [PW-1:0]   w_total;
   logic            w_wd_expired;

   // Configuration legality: kernel must be odd and within range, image
   // dimensions non-zero and within the maximum.
   assign w_cfg_illegal = (cfg_kernel == '0)
                       || !cfg_kernel[0]
                       || (cfg_kernel > LP_K_MAX)
                       || (cfg_max_x == '0)
                       || (cfg_max_x > LP_X_MAX)
                       || (cfg_max_y == '0)
                       || (cfg_max_y > LP_Y_MAX);

   assign w_start_ok  = (r_state == ST_IDLE) && start && !w_cfg_illegal;
   assign w_handshake = (r_state == ST_PRESENT) && win_ready;
   assign w_pix_inc   = r_pix_count + PW'(1);

   // Both operands widened before multiplying so the pixel total never truncates.
   assign w_total = PW'(r_max_x) * PW'(r_max_y);

`ifdef CONV_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [TW-1:0]   r_wd;
   logic            r_timeout_err;
   logic            w_waiting;

   assign w_waiting    = (r_state == ST_DRAIN) || (r_state == ST_FILL);
   assign w_wd_expired = w_waiting && (r_wd == TW'(TIMEOUT_CYCLES - 1));

   // Watchdog counter: counts cycles spent waiting, restarts on every state entry.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wd <= '0;
      end else if (w_state_next != r_state) begin
         r_wd <= '0;
      end else if (w_waiting) begin
         r_wd <= r_wd + TW'(1);
      end
   end

   // Sticky timeout flag, cleared only by the next accepted start.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_timeout_err <= 1'b0;
      end else if (w_start_ok) begin
         r_timeout_err <= 1'b0;
      end else if (w_wd_expired && (w_state_next == ST_IDLE)) begin
         r_timeout_err <= 1'b1;
      end
   end

   assign timeout_err = r_timeout_err;
`else
   assign w_wd_expired = 1'b0;
   assign timeout_err  = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; abort overrides every other transition.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start_ok) begin
               w_state_next = ST_INIT;
            end
         end
         ST_INIT: begin
            w_state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Wait for the previous window's ready to clear before filling.
            if (!new_sample_ready) begin
               w_state_next = ST_FILL;
            end else if (w_wd_expired) begin
               w_state_next = ST_IDLE;
            end
         end
         ST_FILL: begin
            if (new_sample_ready) begin
               w_state_next = ST_PRESENT;
            end else if (w_wd_expired) begin
               w_state_next = ST_IDLE;
            end
         end
         ST_PRESENT: begin
            if (win_ready) begin
               if (w_pix_inc == w_total) begin
                  w_state_next = ST_FINISH;
               end else begin
                  w_state_next = ST_ADVANCE;
               end
            end
         end
         ST_ADVANCE: begin
            w_state_next = ST_DRAIN;
         end
         ST_FINISH: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

      if (abort && (r_state != ST_IDLE)) begin
         w_state_next = ST_IDLE;
      end
   end

   // Latch configuration on an accepted start.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_max_x  <= '0;
         r_max_y  <= '0;
         r_kernel <= '0;
      end else if (w_start_ok) begin
         r_max_x  <= cfg_max_x;
         r_max_y  <= cfg_max_y;
         r_kernel <= cfg_kernel;
      end
   end

   // Accepted-window counter; holds its final value until the next start.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_pix_count <= '0;
      end else if (w_start_ok) begin
         r_pix_count <= '0;
      end else if (w_handshake && !abort) begin
         r_pix_count <= w_pix_inc;
      end
   end

   // One-cycle pulse for a start that carries an illegal configuration.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= (r_state == ST_IDLE) && start && w_cfg_illegal;
      end
   end

   // A running pass must always hold a configuration that passed the legality check.
   always_comb begin
      if (r_state != ST_IDLE) begin
         assert ((r_kernel <= LP_K_MAX) && r_kernel[0]
                 && (r_max_x != '0) && (r_max_y != '0)
                 && (TIMEOUT_CYCLES > 1));
      end
   end

   assign new_trans      = (r_state == ST_INIT);
   assign new_sample_req = (r_state == ST_ADVANCE);
   assign win_valid      = (r_state == ST_PRESENT);
   assign busy           = (r_state != ST_IDLE);
   assign done           = (r_state == ST_FINISH);
   assign cfg_err        = r_cfg_err;
   assign pix_count      = r_pix_count;

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: table of configurations applied in
// a loop, a conv_memory/downstream model, a window scoreboard and a few
// hand-written corner sequences (abort, mid-pass reset, restart, timeout).

module tb_conv_sequencer;

   localparam int X_MAX = 16;
   localparam int Y_MAX = 16;
   localparam int MAX_K = 9;
   localparam int TO    = 32;
   localparam int XW    = $clog2(X_MAX) + 1;
   localparam int YW    = $clog2(Y_MAX) + 1;
   localparam int PW    = $clog2(X_MAX * Y_MAX) + 1;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          start;
   logic          abort;
   logic [XW-1:0] cfg_max_x;
   logic [YW-1:0] cfg_max_y;
   logic [7:0]    cfg_kernel;
   logic          new_trans;
   logic          new_sample_req;
   logic          new_sample_ready = 1'b0;
   logic          win_valid;
   logic          win_ready = 1'b0;
   logic          busy;
   logic          done;
   logic          cfg_err;
   logic          timeout_err;
   logic [PW-1:0] pix_count;

   conv_sequencer #(
      .X_MAX          (X_MAX),
      .Y_MAX          (Y_MAX),
      .MAX_KERNAL     (MAX_K),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk              (clk),
      .n_rst            (n_rst),
      .start            (start),
      .abort            (abort),
      .cfg_max_x        (cfg_max_x),
      .cfg_max_y        (cfg_max_y),
      .cfg_kernel       (cfg_kernel),
      .new_trans        (new_trans),
      .new_sample_req   (new_sample_req),
      .new_sample_ready (new_sample_ready),
      .win_valid        (win_valid),
      .win_ready        (win_ready),
      .busy             (busy),
      .done             (done),
      .cfg_err          (cfg_err),
      .timeout_err      (timeout_err),
      .pix_count        (pix_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   // Model / monitor state
   int lat      = 3;
   bit never    = 1'b0;
   int wrmode   = 0;
   int cnt      = 0;
   int phase    = 0;
   int win_seq  = 0;
   int q[$];
   int n_trans  = 0;
   int n_req    = 0;
   int n_done   = 0;
   int n_cfg    = 0;
   int cyc      = 0;
   int last_req = -1;
   int min_gap  = 1000;
   int exp_total = 0;
   bit prev_wait = 1'b0;
   bit chk_done  = 1'b0;
   bit chk_idle  = 1'b0;

   // conv_memory + downstream model and monitor, all on the falling edge.
   always @(negedge clk) begin
      int e;
      cyc++;
      phase++;
      if (!n_rst) begin
         new_sample_ready = 1'b0;
         cnt       = 0;
         prev_wait = 1'b0;
         chk_done  = 1'b0;
         chk_idle  = 1'b0;
         q.delete();
      end else begin
         // Drive inputs for the coming rising edge.
         if (new_trans || new_sample_req) begin
            new_sample_ready = 1'b0;
            cnt = lat;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0 && !never) begin
               new_sample_ready = 1'b1;
               win_seq++;
               q.push_back(win_seq);
            end
         end
         case (wrmode)
            0:       win_ready = 1'b1;
            1:       win_ready = ((phase % 3) != 0);
            2:       win_ready = ((phase % 4) == 3);
            default: win_ready = 1'b0;
         endcase

         // Observe outputs.
         if (chk_idle) begin
            chk("idle_two_after_last_hs", busy, 0);
            chk_idle = 1'b0;
         end
         if (chk_done) begin
            chk("done_one_after_last_hs", done, 1);
            chk_done = 1'b0;
            chk_idle = 1'b1;
         end
         if (prev_wait) chk("win_valid_hold", win_valid, 1);
         if (new_trans) begin
            n_trans++;
            q.delete();
            win_seq = 0;
         end
         if (new_sample_req) begin
            n_req++;
            if (last_req >= 0 && (cyc - last_req) < min_gap) min_gap = cyc - last_req;
            last_req = cyc;
         end
         if (done)    n_done++;
         if (cfg_err) n_cfg++;
         if (win_valid && win_ready) begin
            if (q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL sb_underflow: handshake with no window pending (t=%0t)", $time);
            end else begin
               e = q.pop_front();
               chk("sb_pix_before_hs", int'(pix_count), e - 1);
               if (e == exp_total) chk_done = 1'b1;
            end
         end
         prev_wait = win_valid && !win_ready;
      end
   end

   typedef struct {
      int x;
      int y;
      int k;
      int lat;
      int wrmode;
      bit err;
      bit restart;
      int pix;
      int req;
   } vec_t;

   task automatic run_vec(input vec_t v);
      int i;
      @(negedge clk);
      n_trans = 0; n_req = 0; n_done = 0; n_cfg = 0;
      min_gap = 1000; last_req = -1;
      lat = v.lat; never = 1'b0; wrmode = v.wrmode; exp_total = v.pix;
      cfg_max_x = XW'(v.x); cfg_max_y = YW'(v.y); cfg_kernel = 8'(v.k);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (v.err) begin
         chk("cfg_err_pulse", cfg_err, 1);
         chk("cfg_err_busy", busy, 0);
         repeat (3) @(negedge clk);
         chk("cfg_err_no_trans", n_trans, 0);
         chk("cfg_err_count", n_cfg, 1);
         chk("cfg_err_still_idle", busy, 0);
      end else begin
         chk("start_busy", busy, 1);
         chk("start_new_trans", new_trans, 1);
         chk("start_no_cfg_err", cfg_err, 0);
         chk("start_timeout_clear", timeout_err, 0);
         if (v.restart) begin
            repeat (3) @(negedge clk);
            cfg_max_x = XW'(2); cfg_max_y = YW'(2); cfg_kernel = 8'(1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("restart_busy", busy, 1);
         end
         for (i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done) break;
         end
         chk("pass_done_seen", done, 1);
         repeat (2) @(negedge clk);
         chk("pass_new_trans", n_trans, 1);
         chk("pass_new_sample_req", n_req, v.req);
         chk("pass_done_count", n_done, 1);
         chk("pass_pix_count", int'(pix_count), v.pix);
         chk("pass_sb_empty", q.size(), 0);
         chk("pass_idle", busy, 0);
         if (v.lat == 2 && v.wrmode == 0 && v.req > 1) chk("min_window_cycles", min_gap, 4);
      end
   endtask

   vec_t tbl[12];

   initial begin
      int i;
      tbl[0]  = '{5,  5,  3,  9, 0, 1'b0, 1'b0, 25,  24};
      tbl[1]  = '{4,  4,  3,  2, 1, 1'b0, 1'b0, 16,  15};
      tbl[2]  = '{5,  5,  4,  3, 0, 1'b1, 1'b0, 0,   0};
      tbl[3]  = '{5,  5,  11, 3, 0, 1'b1, 1'b0, 0,   0};
      tbl[4]  = '{0,  5,  3,  3, 0, 1'b1, 1'b0, 0,   0};
      tbl[5]  = '{1,  1,  1,  3, 0, 1'b0, 1'b0, 1,   0};
      tbl[6]  = '{16, 16, 9,  2, 0, 1'b0, 1'b0, 256, 255};
      tbl[7]  = '{17, 4,  3,  3, 0, 1'b1, 1'b0, 0,   0};
      tbl[8]  = '{4,  17, 3,  3, 0, 1'b1, 1'b0, 0,   0};
      tbl[9]  = '{3,  2,  0,  3, 0, 1'b1, 1'b0, 0,   0};
      tbl[10] = '{2,  3,  5,  3, 2, 1'b0, 1'b0, 6,   5};
      tbl[11] = '{3,  3,  3,  3, 0, 1'b0, 1'b1, 9,   8};

      n_rst = 1'b0; start = 1'b0; abort = 1'b0;
      cfg_max_x = '0; cfg_max_y = '0; cfg_kernel = '0;
      repeat (2) @(negedge clk);
      chk("rst_new_trans", new_trans, 0);
      chk("rst_new_sample_req", new_sample_req, 0);
      chk("rst_win_valid", win_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_pix_count", int'(pix_count), 0);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);

      for (i = 0; i < 12; i++) run_vec(tbl[i]);

      // Abort after the 7th window of a 9x9 pass, then a clean full pass.
      @(negedge clk);
      n_done = 0; lat = 3; wrmode = 0; exp_total = 81;
      cfg_max_x = XW'(9); cfg_max_y = YW'(9); cfg_kernel = 8'(3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (i = 0; i < 2000; i++) begin
         if (pix_count == PW'(7)) break;
         @(negedge clk);
      end
      chk("abort_reached_7", int'(pix_count), 7);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_idle_next", busy, 0);
      chk("abort_pix_count", int'(pix_count), 7);
      repeat (3) @(negedge clk);
      chk("abort_no_done", n_done, 0);
      chk("abort_pix_hold", int'(pix_count), 7);
      run_vec('{9, 9, 3, 3, 0, 1'b0, 1'b0, 81, 80});

      // Asynchronous reset while a window is being presented.
      @(negedge clk);
      lat = 3; wrmode = 0; exp_total = 16;
      cfg_max_x = XW'(4); cfg_max_y = YW'(4); cfg_kernel = 8'(3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (i = 0; i < 2000; i++) begin
         if (win_valid && pix_count == PW'(2)) break;
         @(negedge clk);
      end
      chk("rst_mid_in_present", win_valid, 1);
      #2 n_rst = 1'b0;
      #1;
      chk("rst_mid_win_valid", win_valid, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_pix_count", int'(pix_count), 0);
      chk("rst_mid_new_trans", new_trans, 0);
      chk("rst_mid_new_sample_req", new_sample_req, 0);
      chk("rst_mid_done", done, 0);
      @(negedge clk);
      n_rst = 1'b1;
      run_vec('{2, 2, 1, 2, 0, 1'b0, 1'b0, 4, 3});

`ifdef CONV_SEQ_TIMEOUT_EN
      // Window never becomes ready: watchdog ends the pass after 32 FILL cycles.
      @(negedge clk);
      n_done = 0; lat = 3; never = 1'b1; wrmode = 0; exp_total = 9;
      cfg_max_x = XW'(3); cfg_max_y = YW'(3); cfg_kernel = 8'(3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (i = 0; i < 200; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      chk("timeout_latency", i, 34);
      chk("timeout_flag", timeout_err, 1);
      chk("timeout_no_done", n_done, 0);
      repeat (2) @(negedge clk);
      chk("timeout_sticky", timeout_err, 1);
      run_vec('{2, 2, 3, 3, 0, 1'b0, 1'b0, 4, 3});
`endif

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: bench still running at t=%0t, limit 500000", $time);
      $fatal(1, "time limit reached");
   end

endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Sequences one full-image convolution pass over the `conv_memory` window buffer and the `pixel_pos` scan-position counter. It starts a transaction, waits for each window to fill, presents it to the downstream kernel datapath over a valid/ready handshake, and advances the scan until every pixel has been visited. It sits between the host/top-level control (`start`/`done`) and the `conv_memory` + `pixel_pos` pair.

## Interface
Parameters:
- `X_MAX`, 16, maximum image width in pixels.
- `Y_MAX`, 16, maximum image height in pixels.
- `MAX_KERNAL`, 9, largest supported kernel edge length.
- `TIMEOUT_CYCLES`, 1024, watchdog limit for one window fill; used only with the timeout feature.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `n_rst`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to begin a pass; sampled only in IDLE.
- `abort`  in  1  synchronous abort; returns to IDLE without `done`.
- `cfg_max_x`  in  $clog2(X_MAX)+1  image width; latched on accepted `start`.
- `cfg_max_y`  in  $clog2(Y_MAX)+1  image height; latched on accepted `start`.
- `cfg_kernel`  in  8  kernel edge length; latched on accepted `start`.
- `new_trans`  out  1  one-cycle pulse to `conv_memory`/`pixel_pos` to start a transaction.
- `new_sample_req`  out  1  one-cycle pulse that advances the position and requests the next window.
- `new_sample_ready`  in  1  level from `conv_memory`: the window is valid.
- `win_valid`  out  1  the window is presented downstream.
- `win_ready`  in  1  the downstream datapath accepts the window.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the last window has been accepted.
- `cfg_err`  out  1  one-cycle pulse when `start` carries an illegal configuration.
- `timeout_err`  out  1  sticky watchdog flag; cleared by the next accepted `start` (timeout feature only).
- `pix_count`  out  $clog2(X_MAX*Y_MAX)+1  number of windows accepted in the current pass.

## Operation
- States: IDLE, INIT, DRAIN, FILL, PRESENT, ADVANCE, FINISH.
- IDLE:
  - `start` with a legal configuration latches the config, clears `pix_count` and goes to INIT.
  - `start` with an illegal configuration pulses `cfg_err` and stays in IDLE.
  - An illegal configuration is any of: `cfg_kernel` zero, even, or greater than `MAX_KERNAL`; `cfg_max_x` zero or greater than `X_MAX`; `cfg_max_y` zero or greater than `Y_MAX`.
- INIT: drives `new_trans`=1 for exactly one cycle, then goes to DRAIN.
- DRAIN: waits for `new_sample_ready`=0, then goes to FILL. This guards against a stale ready left over from the previous window.
- FILL: waits for `new_sample_ready`=1, then goes to PRESENT.
- PRESENT:
  - Holds `win_valid`=1 until `win_ready`=1.
  - On the handshake cycle, `pix_count` increments.
  - If the new count equals `max_x*max_y`, go to FINISH; otherwise go to ADVANCE.
- ADVANCE: drives `new_sample_req`=1 for exactly one cycle, then goes to DRAIN.
- FINISH: drives `done`=1 for one cycle, then goes to IDLE. `pix_count` holds its final value until the next accepted `start`.
- `abort`, in any non-IDLE state, forces IDLE on the next edge with no `done` pulse. `abort` has priority over every other transition.
- `start` is ignored while `busy`=1.
- Product `max_x*max_y` is computed at full width ($clog2(X_MAX*Y_MAX)+1 bits) with no truncation.
- Window contents never pass through this block; it only sequences.

## Timing
- Reset values: state IDLE; `new_trans`, `new_sample_req`, `win_valid`, `busy`, `done`, `cfg_err`, `timeout_err` = 0; `pix_count` = 0; latched config = 0.
- All outputs are registered or decoded from state only. No output depends combinationally on `win_ready`, `new_sample_ready` or `start`.
- Accepted `start` at edge N gives `busy`=1 and `new_trans`=1 from cycle N+1.
- Minimum cost per window is 4 cycles: DRAIN, FILL, PRESENT, ADVANCE. This applies when ready is already low in DRAIN, high immediately after, and `win_ready` is held high.
- `win_valid` rises in the cycle after `new_sample_ready` is observed high and must not drop until the handshake completes.
- The last handshake at edge M gives `done`=1 in cycle M+1, then IDLE at M+2.
- A 1x1 image produces one `new_trans`, zero `new_sample_req` pulses and one `done`.
- Reset asserted mid-pass returns all outputs to their reset values immediately (asynchronous).

## Configuration
- `CONV_SEQ_TIMEOUT_EN` defined:
  - A counter runs in DRAIN and FILL and clears on each state entry.
  - On reaching `TIMEOUT_CYCLES`, set `timeout_err`=1 and go to IDLE without `done`.
- `CONV_SEQ_TIMEOUT_EN` undefined:
  - No counter exists.
  - `timeout_err` is tied to 0.
  - DRAIN and FILL wait indefinitely.

## Test plan
- Reset, then `start` with 5x5 and k=3, with a `conv_memory` model giving ready 9 cycles after each request and `win_ready` tied high -> 1 `new_trans`, 24 `new_sample_req`, `pix_count`=25, 1 `done`.
- 4x4, k=3, `win_ready` toggling 1 cycle low / 2 cycles high -> `win_valid` stable until each handshake, no window lost or duplicated, `pix_count`=16.
- `start` with k=4, then k=11, then `cfg_max_x`=0 -> 3 `cfg_err` pulses, `busy` stays 0, no `new_trans`.
- `abort` after the 7th window of 9x9 -> IDLE the next cycle, no `done`, `pix_count`=7; the following `start` runs a clean 81-window pass.
- Reset asserted during PRESENT -> all outputs 0 in the same cycle; a second `start` during a pass is ignored.
- With `CONV_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=32, the model never asserts ready -> `timeout_err`=1 after 32 FILL cycles, no `done`; the next `start` clears it.
